// File: rtl/tcon_pkg.sv
// Shared types and helpers for the test-control multiplexer.
// State encoding, hold-counter width and a channel slice helper.
package tcon_pkg;

    localparam int CNT_W     = 4;
    localparam int MAX_BUS_W = 256;
    localparam int MAX_CH_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        TEST = 2'd2
    } state_e;

    // Returns channel c (w bits wide) of a packed bus, right-aligned.
    function automatic logic [MAX_CH_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int c,
                                                     input int w);
        logic [MAX_BUS_W-1:0] sh;
        logic [MAX_BUS_W-1:0] msk;
        sh  = bus >> (c * w);
        msk = (MAX_BUS_W'(1) << w) - MAX_BUS_W'(1);
        sh  = sh & msk;
        return sh[MAX_CH_W-1:0];
    endfunction

endpackage

// File: rtl/tcon_sel_filter.sv
// Debounces the test-select request and tracks IDLE/ARM/TEST.
// Outputs are direct decodes of registered state; freeze holds state and counter.
module tcon_sel_filter
    import tcon_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sel_i,
    input  logic   freeze,
    output state_e state,
    output logic   active
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            case (state_q)
                IDLE: begin
                    if (sel_i) begin
                        if (HOLD == 1) begin
                            state_d = TEST;
                        end else begin
                            state_d = ARM;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ARM: begin
                    // Any low sample aborts the debounce; the count restarts from IDLE.
                    if (!sel_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(HOLD - 1)) begin
                        state_d = TEST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                TEST: begin
                    if (!sel_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state  = state_q;
    assign active = (state_q == TEST);

endmodule

// File: rtl/tcon_mux_ctrl.sv
// Registered per-channel functional/test mux with a debounced test select.
// Optional scan chain through the mux_o registers when TCON_SCAN_EN is defined.
module tcon_mux_ctrl
    import tcon_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int W    = 1,
    parameter int HOLD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] func_i,
    input  logic [NCH*W-1:0] tst_i,
    input  logic             sel_i,
    input  logic             mask_valid_i,
    input  logic [NCH-1:0]   mask_i,
    output logic             mask_ready_o,
    output logic [NCH*W-1:0] mux_o,
    output logic [NCH*W-1:0] pass_o,
    output logic             active_o
`ifdef TCON_SCAN_EN
    ,
    input  logic             scan_en_i,
    input  logic             scan_si_i,
    output logic             scan_so_o
`endif
);

    localparam int BUS_W = NCH * W;

    state_e             state;
    logic               active;
    logic               shift;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [BUS_W-1:0]   mux_q, mux_d;
    logic [BUS_W-1:0]   pass_q, pass_d;

`ifdef TCON_SCAN_EN
    logic scan_so_q, scan_so_d;
    assign shift     = scan_en_i;
    assign scan_so_o = scan_so_q;
`else
    assign shift = 1'b0;
`endif

    tcon_sel_filter #(.HOLD(HOLD)) u_sel_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel_i  (sel_i),
        .freeze (shift),
        .state  (state),
        .active (active)
    );

    assign active_o     = active;
    assign mask_ready_o = (state == IDLE) && !shift;

    always_comb begin
        mask_d = mask_q;
        pass_d = func_i;
        mux_d  = mux_q;
        if (mask_valid_i && mask_ready_o) begin
            mask_d = mask_i;
        end
        // Selection uses the registered state, so test data lags TEST entry by one edge.
        for (int c = 0; c < NCH; c++) begin
            mux_d[c*W +: W] = (state == TEST && mask_q[c])
                            ? W'(ch_slice(MAX_BUS_W'(tst_i),  c, W))
                            : W'(ch_slice(MAX_BUS_W'(func_i), c, W));
        end
`ifdef TCON_SCAN_EN
        scan_so_d = mux_q[BUS_W-1];
        if (scan_en_i) begin
            mux_d  = BUS_W'({mux_q, scan_si_i});
            pass_d = pass_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '1;
            mux_q  <= '0;
            pass_q <= '0;
        end else begin
            mask_q <= mask_d;
            mux_q  <= mux_d;
            pass_q <= pass_d;
        end
    end

`ifdef TCON_SCAN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_so_q <= 1'b0;
        end else begin
            scan_so_q <= scan_so_d;
        end
    end
`endif

    assign mux_o  = mux_q;
    assign pass_o = pass_q;

endmodule

// File: tb/tb_tcon_mux_ctrl.sv
// Directed plus random checks of tcon_mux_ctrl against a cycle model and a scoreboard.
module tb_tcon_mux_ctrl;

    localparam int NCH  = 8;
    localparam int W    = 1;
    localparam int HOLD = 2;

    typedef struct packed {
        logic [7:0] mux;
        logic [7:0] pass;
        logic       act;
        logic       rdy;
        logic       so;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] func_i, tst_i;
    logic       sel_i, mask_valid_i;
    logic [7:0] mask_i;
    logic       mask_ready_o;
    logic [7:0] mux_o, pass_o;
    logic       active_o;
    logic       scan_en_i, scan_si_i;
`ifdef TCON_SCAN_EN
    logic       scan_so_o;
`endif

    int errors = 0;
    int checks = 0;

    int         m_state, m_cnt;
    logic [7:0] m_mask, m_mux, m_pass;
    logic       m_so;
    exp_t       sbq[$];

    always #5 clk = ~clk;

    tcon_mux_ctrl #(.NCH(NCH), .W(W), .HOLD(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_i       (func_i),
        .tst_i        (tst_i),
        .sel_i        (sel_i),
        .mask_valid_i (mask_valid_i),
        .mask_i       (mask_i),
        .mask_ready_o (mask_ready_o),
        .mux_o        (mux_o),
        .pass_o       (pass_o),
        .active_o     (active_o)
`ifdef TCON_SCAN_EN
        ,
        .scan_en_i    (scan_en_i),
        .scan_si_i    (scan_si_i),
        .scan_so_o    (scan_so_o)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, computed from the inputs currently driven.
    task automatic model_step(output exp_t e);
        logic [7:0] nmux;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_mask = 8'hFF;
            m_mux = 8'h00; m_pass = 8'h00; m_so = 1'b0;
        end else if (scan_en_i) begin
            m_so  = m_mux[7];
            m_mux = {m_mux[6:0], scan_si_i};
        end else begin
            for (int c = 0; c < 8; c++)
                nmux[c] = (m_state == 2 && m_mask[c]) ? tst_i[c] : func_i[c];
            if (mask_valid_i && m_state == 0) m_mask = mask_i;
            m_so   = m_mux[7];
            m_mux  = nmux;
            m_pass = func_i;
            case (m_state)
                0: if (sel_i) begin
                       if (HOLD == 1) m_state = 2;
                       else begin m_state = 1; m_cnt = 1; end
                   end
                1: if (!sel_i) begin m_state = 0; m_cnt = 0; end
                   else if (m_cnt == HOLD - 1) begin m_state = 2; m_cnt = 0; end
                   else m_cnt = m_cnt + 1;
                default: if (!sel_i) m_state = 0;
            endcase
        end
        e.mux  = m_mux;
        e.pass = m_pass;
        e.act  = (m_state == 2);
        e.rdy  = (m_state == 0) && !scan_en_i;
        e.so   = m_so;
    endtask

    task automatic cycle();
        exp_t e;
        model_step(e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_mux",    mux_o,                e.mux);
        chk("sb_pass",   pass_o,               e.pass);
        chk("sb_active", {7'd0, active_o},     {7'd0, e.act});
        chk("sb_ready",  {7'd0, mask_ready_o}, {7'd0, e.rdy});
`ifdef TCON_SCAN_EN
        chk("sb_so",     {7'd0, scan_so_o},    {7'd0, e.so});
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] pat;
        rst_n = 1'b0; func_i = 8'hFF; tst_i = 8'h00; sel_i = 1'b0;
        mask_valid_i = 1'b0; mask_i = 8'h00; scan_en_i = 1'b0; scan_si_i = 1'b0;
        m_state = 0; m_cnt = 0; m_mask = 8'hFF; m_mux = 8'h00; m_pass = 8'h00; m_so = 1'b0;

        // Reset state
        cycle(); cycle();
        chk("rst_mux", mux_o, 8'h00);
        chk("rst_pass", pass_o, 8'h00);
        chk("rst_active", {7'd0, active_o}, 8'h00);
        chk("rst_ready", {7'd0, mask_ready_o}, 8'h01);
        rst_n = 1'b1;
        cycle();
        chk("pass_after_rst", pass_o, 8'hFF);

        // Debounce: one-cycle pulse must not enter TEST
        func_i = 8'h0F; tst_i = 8'hA5;
        cycle();
        sel_i = 1'b1; cycle();
        sel_i = 1'b0; cycle();
        chk("pulse_active", {7'd0, active_o}, 8'h00);
        cycle();
        chk("pulse_mux", mux_o, 8'h0F);

        // Held select: TEST after edge 2, test data after edge 3
        sel_i = 1'b1;
        cycle();
        chk("arm_active", {7'd0, active_o}, 8'h00);
        cycle();
        chk("test_active", {7'd0, active_o}, 8'h01);
        chk("test_mux_lag", mux_o, 8'h0F);
        cycle();
        chk("test_mux", mux_o, 8'hA5);

        // Exit: functional data returns two edges after sel falls
        sel_i = 1'b0;
        cycle();
        chk("exit_mux1", mux_o, 8'hA5);
        cycle();
        chk("exit_mux2", mux_o, 8'h0F);

        // Mask load in IDLE
        mask_valid_i = 1'b1; mask_i = 8'h0F;
        cycle();
        mask_valid_i = 1'b0;
        func_i = 8'h00; tst_i = 8'hFF; sel_i = 1'b1;
        cycle(); cycle(); cycle();
        chk("mask_0f", mux_o, 8'h0F);

        // Stalled load while in TEST
        mask_valid_i = 1'b1; mask_i = 8'h00;
        cycle();
        chk("stall_ready", {7'd0, mask_ready_o}, 8'h00);
        chk("stall_mux", mux_o, 8'h0F);
        cycle();
        chk("stall_mux2", mux_o, 8'h0F);
        sel_i = 1'b0;
        cycle();
        chk("stall_idle_ready", {7'd0, mask_ready_o}, 8'h01);
        cycle();
        mask_valid_i = 1'b0;
        sel_i = 1'b1;
        cycle(); cycle(); cycle();
        chk("mask_00", mux_o, 8'h00);

        // Reset while in TEST
        func_i = 8'h3C;
        rst_n = 1'b0;
        cycle();
        chk("rst_test_mux", mux_o, 8'h00);
        chk("rst_test_active", {7'd0, active_o}, 8'h00);
        rst_n = 1'b1; sel_i = 1'b0;
        cycle();

        // Mask handshake on the same edge as IDLE->ARM
        sel_i = 1'b1; mask_valid_i = 1'b1; mask_i = 8'hF0;
        cycle();
        mask_valid_i = 1'b0; func_i = 8'h00; tst_i = 8'hFF;
        cycle(); cycle();
        chk("mask_at_arm", mux_o, 8'hF0);
        sel_i = 1'b0;
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            func_i       = 8'($urandom);
            tst_i        = 8'($urandom);
            sel_i        = ($urandom_range(0, 3) != 0);
            mask_valid_i = ($urandom_range(0, 3) == 0);
            mask_i       = 8'($urandom);
            cycle();
        end
        mask_valid_i = 1'b0; sel_i = 1'b0;

`ifdef TCON_SCAN_EN
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        func_i = 8'h55; cycle();
        pat = 8'b10110001;
        scan_en_i = 1'b1; sel_i = 1'b1; func_i = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            scan_si_i = pat[i];
            cycle();
            chk("scan_frozen", {7'd0, active_o}, 8'h00);
        end
        chk("scan_load", mux_o, 8'b10001101);
        chk("scan_pass_frozen", pass_o, 8'h55);
        scan_si_i = 1'b0;
        got = 8'h00;
        for (int j = 0; j < 8; j++) begin
            cycle();
            got[7-j] = scan_so_o;
        end
        chk("scan_so_seq", got, 8'b10001101);
        scan_en_i = 1'b0; sel_i = 1'b0;
        cycle();
        chk("scan_exit_idle", {7'd0, mask_ready_o}, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
